// File: rtl/spectrum_pkg.sv
// spectrum_pkg: shared types and helpers for the spectrum analyzer read path.
//
// Contents:
//   DEFAULT_DEPTH / DEFAULT_FRAME_LEN / DEFAULT_DW : default sizing.
//   state_e  : frame reader FSM states (IDLE, STREAM, DONE).
//   wrap_inc : (addr + 1) mod depth, without a divider.
//   wrap_dec : (addr - 1) mod depth, without a divider.
package spectrum_pkg;

  localparam int DEFAULT_DEPTH     = 16;
  localparam int DEFAULT_FRAME_LEN = 16;
  localparam int DEFAULT_DW        = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

  // The depth need not be a power of two, so wrap by compare, not by truncation.
  function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned depth);
    return (addr >= depth - 1) ? 0 : addr + 1;
  endfunction

  function automatic int unsigned wrap_dec(input int unsigned addr, input int unsigned depth);
    return (addr == 0) ? depth - 1 : addr - 1;
  endfunction

endpackage

// File: rtl/frame_skid2.sv
// frame_skid2: two-entry FIFO carrying {last, data} between the RAM read
// pipeline and the output stream.
//
// Ports:
//   clk, RE_n          clock, asynchronous active-low reset
//   push, push_data    write one entry (ignored when full and not popping)
//   pop                remove the head entry (ignored when empty)
//   valid              FIFO holds at least one entry
//   head               oldest entry; unchanged until popped
//   occupancy          number of stored entries (0..2)
module frame_skid2
  import spectrum_pkg::*;
#(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         RE_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic [1:0]   occupancy
);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop;

  assign valid     = (count_q != 2'd0);
  assign head      = slot0_q;
  assign occupancy = count_q;
  assign do_pop    = pop && valid;

  // slot0 is always the head, so the output only changes on a pop or on the
  // first push into an empty FIFO.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          slot0_d = push_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && do_pop) begin
          slot0_d = push_data;
        end else if (do_pop) begin
          count_d = 2'd0;
        end else if (push) begin
          slot1_d = push_data;
          count_d = 2'd2;
        end
      end
      2'd2: begin
        if (do_pop) begin
          slot0_d = slot1_q;
          if (push) begin
            slot1_d = push_data;
          end else begin
            count_d = 2'd1;
          end
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge RE_n) begin
    if (!RE_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/spectrum_frame_reader.sv
// spectrum_frame_reader: reads one frame of FRAME_LEN samples out of the
// circular sample buffer, oldest first, and streams them downstream.
//
// On start (in IDLE) the write pointer is captured as the frame base. Reads
// are issued to a RAM with one cycle of read latency; returned words land in
// a 2-entry FIFO that drives the output stream. A read is only issued when the
// FIFO is guaranteed to have room for it when it returns.
//
// Stream handshake: a sample transfers on a rising edge where m_valid and
// m_ready are both 1; while m_valid=1 and m_ready=0, m_data and m_last hold.
//
// Optional feature (macro REVERSE_READ_EN): adds input dir, captured at
// start. dir=1 reads newest-first, starting at wr_ptr-1 and stepping down.
//
// Ports:
//   clk, RE_n       clock, asynchronous active-low reset
//   start           frame request, honoured only in IDLE
//   dir             read direction (only with REVERSE_READ_EN)
//   wr_ptr          writer's next slot = oldest sample
//   rd_en, rd_addr  RAM read strobe / address
//   rd_data         RAM data, valid the cycle after rd_en
//   m_valid, m_ready, m_data, m_last   output sample stream
//   busy            any state other than IDLE
//   done            one-cycle pulse after the final sample is accepted
//   dbg_state       current FSM state
module spectrum_frame_reader
  import spectrum_pkg::*;
#(
  parameter  int DEPTH     = DEFAULT_DEPTH,
  parameter  int FRAME_LEN = DEFAULT_FRAME_LEN,
  parameter  int DW        = DEFAULT_DW,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          RE_n,
  input  logic          start,
`ifdef REVERSE_READ_EN
  input  logic          dir,
`endif
  input  logic [AW-1:0] wr_ptr,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  localparam int            CW       = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] FL_C     = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0] issued_q, issued_d;
  logic          inflight_q, inflight_d;
  logic          inflight_last_q, inflight_last_d;
  logic          rev_q, rev_d;

  logic          start_dir;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] next_addr;
  logic          can_issue;

  logic          fifo_valid;
  logic [DW:0]   fifo_head;
  logic [1:0]    fifo_occ;
  logic          pop;
  logic          head_last;

`ifdef REVERSE_READ_EN
  assign start_dir = dir;
`else
  assign start_dir = 1'b0;
`endif

  // Output FIFO: each entry is {last, sample}.
  frame_skid2 #(.W(DW + 1)) u_skid (
    .clk       (clk),
    .RE_n      (RE_n),
    .push      (inflight_q),
    .push_data ({inflight_last_q, rd_data}),
    .pop       (pop),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .occupancy (fifo_occ)
  );

  assign pop       = fifo_valid && m_ready;
  assign head_last = fifo_head[DW];
  assign m_valid   = fifo_valid;
  assign m_data    = fifo_head[DW-1:0];
  assign m_last    = fifo_valid && head_last;
  assign rd_addr   = rd_addr_q;
  assign dbg_state = state_q;

  // Credit: 2 - occupancy - inflight + pop > 0. A slot freed by this cycle's
  // pop can be reused, which is what keeps the stream bubble-free.
  assign can_issue = ({1'b0, fifo_occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

  always_comb begin
    base_addr = wr_ptr;
    if (start_dir) begin
      base_addr = AW'(wrap_dec(32'(wr_ptr), DEPTH));
    end
  end

  always_comb begin
    next_addr = AW'(wrap_inc(32'(rd_addr_q), DEPTH));
    if (rev_q) begin
      next_addr = AW'(wrap_dec(32'(rd_addr_q), DEPTH));
    end
  end

  // State register and all datapath flops.
  always_ff @(posedge clk or negedge RE_n) begin
    if (!RE_n) begin
      state_q         <= IDLE;
      rd_addr_q       <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rev_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_addr_q       <= rd_addr_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      rev_q           <= rev_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (pop && head_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    rd_en = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    case (state_q)
      IDLE:    busy  = 1'b0;
      STREAM:  rd_en = (issued_q < FL_C) && can_issue;
      DONE:    done  = 1'b1;
      default: busy  = 1'b0;
    endcase
  end

  // Address / issue counter and read-pipeline tracking. The last flag rides
  // with the read so the FIFO entry knows it ends the frame.
  always_comb begin
    rd_addr_d       = rd_addr_q;
    issued_d        = issued_q;
    rev_d           = rev_q;
    inflight_d      = rd_en;
    inflight_last_d = rd_en && (issued_q == LAST_IDX);
    if ((state_q == IDLE) && start) begin
      rd_addr_d = base_addr;
      issued_d  = '0;
      rev_d     = start_dir;
    end else if (rd_en) begin
      rd_addr_d = next_addr;
      issued_d  = issued_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_spectrum_frame_reader.sv
// Bench for spectrum_frame_reader. Three instances share clock and reset:
//   inst0 DEPTH=16 FRAME_LEN=16, inst1 DEPTH=10 FRAME_LEN=10,
//   inst2 DEPTH=16 FRAME_LEN=3.
// The reference model builds each frame's expected sample list from the RAM
// contents and the captured base, and tracks busy/done and read issue.
module tb_spectrum_frame_reader;

  localparam int DW = 12;
  localparam int AW = 4;
  localparam int NI = 3;
`ifdef REVERSE_READ_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  function automatic int dep_of(input int i);
    return (i == 1) ? 10 : 16;
  endfunction

  function automatic int fl_of(input int i);
    return (i == 0) ? 16 : ((i == 1) ? 10 : 3);
  endfunction

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic RE_n = 1'b1;
  always #5 clk = ~clk;

  logic          start     [NI];
  logic          dir       [NI];
  logic [AW-1:0] wr_ptr    [NI];
  logic          rd_en     [NI];
  logic [AW-1:0] rd_addr   [NI];
  logic [DW-1:0] rd_data   [NI];
  logic          m_valid   [NI];
  logic          m_ready   [NI];
  logic [DW-1:0] m_data    [NI];
  logic          m_last    [NI];
  logic          busy      [NI];
  logic          done      [NI];
  logic [1:0]    dbg_state [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    spectrum_frame_reader #(
      .DEPTH     ((g == 1) ? 10 : 16),
      .FRAME_LEN ((g == 0) ? 16 : ((g == 1) ? 10 : 3)),
      .DW        (DW)
    ) u_dut (
      .clk       (clk),
      .RE_n      (RE_n),
      .start     (start[g]),
`ifdef REVERSE_READ_EN
      .dir       (dir[g]),
`endif
      .wr_ptr    (wr_ptr[g]),
      .rd_en     (rd_en[g]),
      .rd_addr   (rd_addr[g]),
      .rd_data   (rd_data[g]),
      .m_valid   (m_valid[g]),
      .m_ready   (m_ready[g]),
      .m_data    (m_data[g]),
      .m_last    (m_last[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .dbg_state (dbg_state[g])
    );
  end

  // RAM model: one-cycle read latency; garbage on the bus when not reading.
  logic [DW-1:0] ram [NI][16];
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      rd_data[i] <= rd_en[i] ? ram[i][rd_addr[i]] : DW'($urandom);
    end
  end

  // ---------------- scoreboard state ----------------
  logic [DW:0] exp_q [NI][$];
  bit m_busy [NI];
  bit done_pend [NI];
  bit mdir [NI];
  bit in_frame_v [NI];
  int base [NI];
  int n_rd [NI];
  int n_acc [NI];
  int done_cnt [NI];
  int start_cyc [NI];
  int first_v_cyc [NI];
  int done_cyc [NI];
  int mfirst [NI];
  int mlast [NI];
  int rmode [NI];
  int cyc;
  int tests;
  int fails;

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d t=%0t: got %0d, expected %0d", name, inst, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      exp_q[i].delete();
      m_busy[i]     = 1'b0;
      done_pend[i]  = 1'b0;
      n_rd[i]       = 0;
      n_acc[i]      = 0;
      in_frame_v[i] = 1'b0;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    cyc++;
    if (RE_n) begin
      for (int i = 0; i < NI; i++) begin
        bit was_busy;
        bit hs;
        bit hs_last;
        int d;
        int exp_a;
        d        = dep_of(i);
        was_busy = m_busy[i];
        hs       = (m_valid[i] === 1'b1) && (m_ready[i] === 1'b1) && (exp_q[i].size() > 0);
        hs_last  = 1'b0;

        check("busy", i, 32'(busy[i]), 32'(m_busy[i]));
        check("done", i, 32'(done[i]), 32'(done_pend[i]));

        if (rd_en[i] === 1'b1) begin
          exp_a = mdir[i] ? ((base[i] + d - n_rd[i]) % d) : ((base[i] + n_rd[i]) % d);
          check("rd_in_stream", i, 32'(was_busy && !done_pend[i]), 1);
          check("rd_credit", i, 32'((n_rd[i] - n_acc[i] - int'(hs)) < 2), 1);
          check("rd_count", i, 32'(n_rd[i] < fl_of(i)), 1);
          check("rd_addr", i, 32'(rd_addr[i]), 32'(exp_a));
          n_rd[i]++;
        end

        if (m_valid[i] === 1'b1) begin
          check("valid_expected", i, 32'(exp_q[i].size() > 0), 1);
          if (exp_q[i].size() > 0) begin
            check("m_data", i, 32'(m_data[i]), 32'(exp_q[i][0][DW-1:0]));
            check("m_last", i, 32'(m_last[i]), 32'(exp_q[i][0][DW]));
            if (!in_frame_v[i]) begin
              in_frame_v[i]  = 1'b1;
              first_v_cyc[i] = cyc;
            end
            if (hs) begin
              hs_last = exp_q[i][0][DW];
              void'(exp_q[i].pop_front());
              n_acc[i]++;
            end
          end
        end else begin
          check("m_last_idle", i, 32'(m_last[i]), 0);
        end

        if (done_pend[i]) begin
          done_pend[i] = 1'b0;
          m_busy[i]    = 1'b0;
          done_cnt[i]++;
          done_cyc[i]  = cyc;
        end else if (hs_last) begin
          done_pend[i] = 1'b1;
        end

        if ((start[i] === 1'b1) && !was_busy) begin
          int fl;
          int a;
          fl      = fl_of(i);
          m_busy[i] = 1'b1;
          mdir[i] = DIR_EN && dir[i];
          base[i] = mdir[i] ? ((int'(wr_ptr[i]) + d - 1) % d) : int'(wr_ptr[i]);
          exp_q[i].delete();
          for (int k = 0; k < fl; k++) begin
            a = mdir[i] ? ((base[i] + d - k) % d) : ((base[i] + k) % d);
            exp_q[i].push_back({(k == fl - 1), ram[i][a]});
            if (k == 0) mfirst[i] = int'(ram[i][a]);
            if (k == fl - 1) mlast[i] = int'(ram[i][a]);
          end
          n_rd[i]       = 0;
          n_acc[i]      = 0;
          in_frame_v[i] = 1'b0;
          start_cyc[i]  = cyc;
        end
      end
    end
  end

  // ---------------- m_ready generator ----------------
  // mode 0: always ready; 1: repeating 1,0,0,1; 2: random.
  initial begin
    for (int i = 0; i < NI; i++) m_ready[i] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        case (rmode[i])
          0:       m_ready[i] = 1'b1;
          1:       m_ready[i] = ((cyc % 4) == 0) || ((cyc % 4) == 3);
          default: m_ready[i] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_frame(input int i, input int wp, input bit dv, input int mode,
                           input bit jitter, input bit poke);
    int d0;
    rmode[i]  = mode;
    wr_ptr[i] = AW'(wp);
    dir[i]    = dv;
    start[i]  = 1'b1;
    d0        = done_cnt[i];
    @(posedge clk);
    #1;
    start[i] = 1'b0;
    for (int c = 0; c < 400 && done_cnt[i] == d0; c++) begin
      if (jitter) begin
        wr_ptr[i] = AW'($urandom_range(0, dep_of(i) - 1));
        if ($urandom_range(0, 7) == 0) start[i] = 1'b1;
      end
      if (poke && c == 1) begin
        wr_ptr[i] = AW'(3);
        start[i]  = 1'b1;
      end
      @(posedge clk);
      #1;
      start[i] = 1'b0;
    end
    check("done_seen", i, 32'(done_cnt[i] != d0), 1);
    check("frame_drained", i, 32'(exp_q[i].size()), 0);
    rmode[i] = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      check({tag, "_rd_en"}, i, 32'(rd_en[i]), 0);
      check({tag, "_rd_addr"}, i, 32'(rd_addr[i]), 0);
      check({tag, "_m_valid"}, i, 32'(m_valid[i]), 0);
      check({tag, "_m_data"}, i, 32'(m_data[i]), 0);
      check({tag, "_m_last"}, i, 32'(m_last[i]), 0);
      check({tag, "_busy"}, i, 32'(busy[i]), 0);
      check({tag, "_done"}, i, 32'(done[i]), 0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    for (int i = 0; i < NI; i++) begin
      start[i]  = 1'b0;
      dir[i]    = 1'b0;
      wr_ptr[i] = '0;
      rmode[i]  = 0;
      for (int a = 0; a < 16; a++) ram[i][a] = DW'(a);
    end

    #1 RE_n = 1'b0;
    #1 check_outputs_zero("rst");
    repeat (2) @(posedge clk);
    #3 RE_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame, always ready.
    run_frame(0, 5, 1'b0, 0, 1'b0, 1'b0);
    check("basic_first", 0, 32'(mfirst[0]), 5);
    check("basic_last", 0, 32'(mlast[0]), 4);
    check("basic_latency", 0, 32'(first_v_cyc[0] - start_cyc[0]), 3);
    check("basic_start_to_done", 0, 32'(done_cyc[0] - start_cyc[0]), 19);

    // Backpressure 1,0,0,1 with wr_ptr moving during the frame.
    run_frame(0, 5, 1'b0, 1, 1'b1, 1'b0);
    check("bp_first", 0, 32'(mfirst[0]), 5);

    // Non-power-of-two depth.
    run_frame(1, 9, 1'b0, 0, 1'b1, 1'b0);
    check("np2_first", 1, 32'(mfirst[1]), 9);
    check("np2_last", 1, 32'(mlast[1]), 8);

    // Short frame with a second start pulsed mid-frame.
    d0 = done_cnt[2];
    run_frame(2, 15, 1'b0, 0, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("short_done_count", 2, 32'(done_cnt[2] - d0), 1);
    check("short_first", 2, 32'(mfirst[2]), 15);
    check("short_last", 2, 32'(mlast[2]), 1);

    // Reset mid-frame after 4 accepted samples.
    rmode[0]  = 0;
    wr_ptr[0] = AW'(7);
    start[0]  = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    for (int c = 0; c < 100 && n_acc[0] < 4; c++) begin
      @(posedge clk);
      #1;
    end
    check("mid_reset_reached", 0, 32'(n_acc[0] >= 4), 1);
    #1 RE_n = 1'b0;
    #1 check_outputs_zero("midrst");
    model_clear();
    repeat (2) @(posedge clk);
    #3 RE_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(0, 2, 1'b0, 0, 1'b0, 1'b0);
    check("after_reset_first", 0, 32'(mfirst[0]), 2);
    check("after_reset_last", 0, 32'(mlast[0]), 1);

`ifdef REVERSE_READ_EN
    run_frame(0, 0, 1'b1, 0, 1'b0, 1'b0);
    check("rev_first", 0, 32'(mfirst[0]), 15);
    check("rev_last", 0, 32'(mlast[0]), 0);
    run_frame(1, 0, 1'b1, 2, 1'b1, 1'b0);
    check("rev_np2_first", 1, 32'(mfirst[1]), 9);
`endif

    // Randomized frames over random RAM contents.
    for (int i = 0; i < NI; i++) begin
      for (int a = 0; a < 16; a++) ram[i][a] = DW'($urandom);
    end
    for (int f = 0; f < 24; f++) begin
      int i;
      bit dv;
      i  = $urandom_range(0, NI - 1);
      dv = 1'b0;
`ifdef REVERSE_READ_EN
      dv = 1'($urandom_range(0, 1));
`endif
      run_frame(i, $urandom_range(0, dep_of(i) - 1), dv, $urandom_range(0, 2), 1'b1, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
